// File: rtl/trit_resolve_scheduler.sv
// Round-robin front end that shares one trit resolver among NUM_REQ requesters.
// Define TRS_STATS_EN to add the saturating stat_pos/stat_neg/stat_err counters.
module trit_resolve_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [2*NUM_REQ-1:0] req_state,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [1:0]           rsp_state,
    output logic                 rsp_err,
    output logic                 nt_start,
    output logic [1:0]           nt_state,
    input  logic [1:0]           nt_resolved,
    output logic                 busy
`ifdef TRS_STATS_EN
    ,
    output logic [CNT_W-1:0]     stat_pos,
    output logic [CNT_W-1:0]     stat_neg,
    output logic [CNT_W-1:0]     stat_err
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant_id;
    logic            grant_found;
    logic [1:0]      grant_state;
    logic            accept;
    logic            rsp_hs;

    function automatic logic [ID_W-1:0] rot_idx(input logic [ID_W-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return ID_W'(sum);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Descending scan so the lowest offset from rr_ptr is the one that sticks.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[rot_idx(rr_ptr, k)]) begin
                grant_found = 1'b1;
                grant_id    = rot_idx(rr_ptr, k);
            end
        end
    end

    assign grant_state = req_state[{grant_id, 1'b0} +: 2];
    assign accept      = (state == S_IDLE) && grant_found;
    assign rsp_hs      = rsp_valid && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant_found) state_nxt = (grant_state == 2'b11) ? S_RESP : S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // req_ready is combinational, so it is masked while reset is held.
    always_comb begin
        req_ready = '0;
        nt_start  = 1'b0;
        busy      = (state != S_IDLE);
        if ((state == S_IDLE) && grant_found && rst_n) req_ready[grant_id] = 1'b1;
        if (state == S_ISSUE) nt_start = 1'b1;
    end

    // An illegal code skips the resolver; codes 10/11 coming back from it are flagged via bit 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_state <= 2'b00;
            rsp_err   <= 1'b0;
            nt_state  <= 2'b00;
        end else begin
            if (accept) begin
                rsp_id <= grant_id;
                if (grant_state == 2'b11) begin
                    rsp_state <= 2'b11;
                    rsp_err   <= 1'b1;
                    rsp_valid <= 1'b1;
                end else begin
                    nt_state  <= grant_state;
                end
            end
            if (state == S_WAIT) begin
                rsp_state <= nt_resolved;
                rsp_err   <= nt_resolved[1];
                rsp_valid <= 1'b1;
            end
            if (rsp_hs) begin
                rsp_valid <= 1'b0;
                rr_ptr    <= rot_idx(rsp_id, 1);
            end
        end
    end

`ifdef TRS_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_pos <= '0;
            stat_neg <= '0;
            stat_err <= '0;
        end else if (rsp_hs) begin
            if (rsp_err)                 stat_err <= sat_inc(stat_err);
            else if (rsp_state == 2'b00) stat_pos <= sat_inc(stat_pos);
            else                         stat_neg <= sat_inc(stat_neg);
        end
    end
`endif

endmodule
